// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among per-thread LSU ports.
// Optional watchdog on memory wait states enabled by defining MEM_TIMEOUT_EN.
module lsu_mem_arbiter #(
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_THREADS-1:0]                lsu_read_valid,
  input  logic [NUM_THREADS-1:0]                lsu_write_valid,
  input  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] lsu_read_addr,
  input  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] lsu_write_addr,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_write_data,
  output logic [NUM_THREADS-1:0]                lsu_ready,
  output logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_read_data,
  output logic                                  mem_read_valid,
  output logic [ADDR_BITS-1:0]                  mem_read_addr,
  input  logic                                  mem_read_ready,
  input  logic [DATA_BITS-1:0]                  mem_read_data,
  output logic                                  mem_write_valid,
  output logic [ADDR_BITS-1:0]                  mem_write_addr,
  output logic [DATA_BITS-1:0]                  mem_write_data,
  input  logic                                  mem_write_ready,
  output logic                                  arb_error
);

  localparam int unsigned IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  if (NUM_THREADS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("lsu_mem_arbiter: NUM_THREADS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELEASE    = 2'd3
  } state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      g_q, g_d;
  logic [IDX_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [NUM_THREADS-1:0]                lsu_ready_q, lsu_ready_d;
  logic [NUM_THREADS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic                                  mem_rvalid_q, mem_rvalid_d;
  logic                                  mem_wvalid_q, mem_wvalid_d;
  logic [ADDR_BITS-1:0]                  mem_raddr_q, mem_raddr_d;
  logic [ADDR_BITS-1:0]                  mem_waddr_q, mem_waddr_d;
  logic [DATA_BITS-1:0]                  mem_wdata_q, mem_wdata_d;

  logic             pick_found_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_is_read_c;
  logic             ready_match_c;
  logic             timeout_c;
  logic             mem_done_c;

  // First requester at or after rr_ptr, wrapping modulo NUM_THREADS
  always_comb begin
    int unsigned idx;
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    idx          = 0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_THREADS;
      if (!pick_found_c && (lsu_read_valid[IDX_W'(idx)] || lsu_write_valid[IDX_W'(idx)])) begin
        pick_found_c = 1'b1;
        pick_idx_c   = IDX_W'(idx);
      end
    end
    pick_is_read_c = lsu_read_valid[pick_idx_c];
  end

  assign ready_match_c = ((state_q == ST_READ_WAIT)  && mem_read_ready) ||
                         ((state_q == ST_WRITE_WAIT) && mem_write_ready);
  assign mem_done_c    = ready_match_c || timeout_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Counts cycles spent in the current WAIT state; restarts on every entry
  always_comb begin
    timeout_c  = 1'b0;
    wait_cnt_d = '0;
    err_d      = err_q;
    if ((state_q == ST_READ_WAIT) || (state_q == ST_WRITE_WAIT)) begin
      timeout_c  = !ready_match_c && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end
    if (timeout_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign arb_error = err_q;
`else
  assign timeout_c = 1'b0;
  assign arb_error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          g_d     = pick_idx_c;
          state_d = pick_is_read_c ? ST_READ_WAIT : ST_WRITE_WAIT;
        end
      end
      ST_READ_WAIT, ST_WRITE_WAIT: begin
        if (mem_done_c) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (32'(g_q) == NUM_THREADS - 1) ? '0 : g_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values, registered alongside the state
  always_comb begin
    lsu_ready_d  = '0;
    rdata_d      = rdata_q;
    mem_rvalid_d = (state_d == ST_READ_WAIT);
    mem_wvalid_d = (state_d == ST_WRITE_WAIT);
    mem_raddr_d  = mem_raddr_q;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    if (state_d == ST_RELEASE) begin
      lsu_ready_d[g_d] = 1'b1;
    end
    if ((state_q == ST_IDLE) && pick_found_c) begin
      if (pick_is_read_c) begin
        mem_raddr_d = lsu_read_addr[pick_idx_c];
      end else begin
        mem_waddr_d = lsu_write_addr[pick_idx_c];
        mem_wdata_d = lsu_write_data[pick_idx_c];
      end
    end
    // A real response takes priority over a coincident timeout
    if (state_q == ST_READ_WAIT) begin
      if (mem_read_ready) begin
        rdata_d[g_q] = mem_read_data;
      end else if (timeout_c) begin
        rdata_d[g_q] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_ready_q  <= '0;
      rdata_q      <= '0;
      mem_rvalid_q <= 1'b0;
      mem_wvalid_q <= 1'b0;
      mem_raddr_q  <= '0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      lsu_ready_q  <= lsu_ready_d;
      rdata_q      <= rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign lsu_ready       = lsu_ready_q;
  assign lsu_read_data   = rdata_q;
  assign mem_read_valid  = mem_rvalid_q;
  assign mem_read_addr   = mem_raddr_q;
  assign mem_write_valid = mem_wvalid_q;
  assign mem_write_addr  = mem_waddr_q;
  assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: transaction-level model of grants, memory and LSU handshakes.
// Also exercises the watchdog when compiled with MEM_TIMEOUT_EN.
module tb_lsu_mem_arbiter;

  localparam int unsigned NT = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NT-1:0]        rv, wv;
  logic [NT-1:0][AW-1:0] raddr, waddr;
  logic [NT-1:0][DW-1:0] wdata;
  logic [NT-1:0]        lsu_ready;
  logic [NT-1:0][DW-1:0] lsu_rdata;
  logic                 mrv, mrr, mwv, mwr;
  logic [AW-1:0]        mra, mwa;
  logic [DW-1:0]        mrd, mwd;
  logic                 arb_error;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .NUM_THREADS(NT), .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .reset(reset),
    .lsu_read_valid(rv), .lsu_write_valid(wv),
    .lsu_read_addr(raddr), .lsu_write_addr(waddr), .lsu_write_data(wdata),
    .lsu_ready(lsu_ready), .lsu_read_data(lsu_rdata),
    .mem_read_valid(mrv), .mem_read_addr(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_addr(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr), .arb_error(arb_error)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: the arbiter is FREE, WAITing on memory for thread g, or RELeasing g
  typedef enum {M_FREE, M_WAIT, M_REL, M_RST} ph_e;
  ph_e ph = M_FREE;
  ph_e nxt;
  int  rr = 0;
  int  g = 0;
  bit  g_rd;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  int  wait_left, waited;
  logic [NT-1:0][DW-1:0] m_rdata = '0;
  bit  m_err = 1'b0;
  logic [DW-1:0] mem [256];
  int  wait_force = -1;
  bit  do_reset = 1'b0;
  int  served[$];

  task automatic spurious();
    mrr = 1'($urandom_range(0, 1));
    mwr = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    mrr = 1'b0;
    mwr = 1'b0;
    mrd = DW'($urandom);
    nxt = ph;
    if (do_reset) begin
      reset = 1'b1;
      nxt   = M_RST;
    end else begin
      case (ph)
        M_FREE: begin
          spurious();
          for (int i = 0; i < NT; i++) begin
            int t;
            t = (rr + i) % NT;
            if (nxt == M_FREE && (rv[t] || wv[t])) begin
              g         = t;
              g_rd      = rv[t];
              g_addr    = rv[t] ? raddr[t] : waddr[t];
              g_data    = wdata[t];
              wait_left = (wait_force < 0) ? int'($urandom_range(0, 3)) : wait_force;
              waited    = 0;
              nxt       = M_WAIT;
            end
          end
        end
        M_WAIT: begin
          waited++;
          if (wait_left == 0) begin
            if (g_rd) begin
              mrr        = 1'b1;
              mrd        = mem[g_addr];
              m_rdata[g] = mem[g_addr];
            end else begin
              mwr          = 1'b1;
              mem[g_addr]  = g_data;
            end
            nxt = M_REL;
          end else begin
            wait_left--;
            if (g_rd) mwr = 1'($urandom_range(0, 1));
            else      mrr = 1'($urandom_range(0, 1));
            if (TO_EN && waited == TO) begin
              nxt   = M_REL;
              m_err = 1'b1;
              if (g_rd) m_rdata[g] = '1;
            end
          end
        end
        M_REL: begin
          spurious();
          rr  = (g + 1) % NT;
          nxt = M_FREE;
        end
        default: nxt = M_FREE;
      endcase
    end
    @(negedge clk);
    reset = 1'b0;
    ph    = nxt;
    for (int i = 0; i < NT; i++) if (lsu_ready[i]) served.push_back(i);
    case (ph)
      M_RST: begin
        rr      = 0;
        m_rdata = '0;
        m_err   = 1'b0;
        check("rst_mrv", 64'(mrv), 64'(0));
        check("rst_mwv", 64'(mwv), 64'(0));
        check("rst_rdy", 64'(lsu_ready), 64'(0));
        check("rst_rdata", 64'(lsu_rdata), 64'(0));
        check("rst_maddr", 64'({mra, mwa, mwd}), 64'(0));
        ph = M_FREE;
      end
      M_FREE: begin
        check("idle_mv", 64'({mrv, mwv}), 64'(0));
        check("idle_rdy", 64'(lsu_ready), 64'(0));
      end
      M_WAIT: begin
        check("wait_rdy", 64'(lsu_ready), 64'(0));
        if (g_rd) begin
          check("rd_mv", 64'({mrv, mwv}), 64'(2'b10));
          check("rd_addr", 64'(mra), 64'(g_addr));
        end else begin
          check("wr_mv", 64'({mrv, mwv}), 64'(2'b01));
          check("wr_addr", 64'(mwa), 64'(g_addr));
          check("wr_data", 64'(mwd), 64'(g_data));
        end
      end
      M_REL: begin
        check("rel_mv", 64'({mrv, mwv}), 64'(0));
        check("rel_rdy", 64'(lsu_ready), 64'(1) << g);
        check("rel_rdata", 64'(lsu_rdata), 64'(m_rdata));
        if (g_rd) rv[g] = 1'b0;
        else      wv[g] = 1'b0;
      end
      default: ;
    endcase
    check("arb_err", 64'(arb_error), 64'(m_err));
  endtask

  task automatic gen_random();
    for (int t = 0; t < NT; t++) begin
      if (!rv[t] && $urandom_range(0, 3) == 0) begin
        rv[t]    = 1'b1;
        raddr[t] = AW'($urandom);
      end
      if (!wv[t] && $urandom_range(0, 4) == 0) begin
        wv[t]    = 1'b1;
        waddr[t] = AW'($urandom);
        wdata[t] = DW'($urandom);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (rv != 0 || wv != 0 || ph != M_FREE); k++) step();
    check("drained", 64'({rv, wv}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0;
    rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);

    @(negedge clk);
    do_reset = 1'b1; step(); do_reset = 1'b0;
    step();

    // Single read: thread 2, addr 0x10, two memory wait cycles
    mem[8'h10] = 8'hA5;
    served.delete();
    raddr[2] = 8'h10; rv[2] = 1'b1; wait_force = 2;
    repeat (6) step();
    check("rd2_data", 64'(lsu_rdata[2]), 64'(8'hA5));
    check("rd2_once", 64'(served.size()), 64'(1));

    // Single write: thread 1 writes 0x3C to 0x20, immediate ready
    served.delete();
    waddr[1] = 8'h20; wdata[1] = 8'h3C; wv[1] = 1'b1; wait_force = 0;
    repeat (5) step();
    check("wr1_once", 64'(served.size()), 64'(1));

    // Contention from reset: all threads read together
    do_reset = 1'b1; step(); do_reset = 1'b0;
    served.delete();
    for (int t = 0; t < NT; t++) begin raddr[t] = AW'(8'h40 + t); rv[t] = 1'b1; end
    wait_force = -1;
    repeat (30) step();
    check("cont_cnt", 64'(served.size()), 64'(NT));
    for (int i = 0; i < NT && i < served.size(); i++) check("cont_order", 64'(served[i]), 64'(i));

    // Fairness: thread 0 re-requests right away, thread 3 holds
    drain();
    served.delete();
    raddr[0] = 8'h55; rv[0] = 1'b1;
    raddr[3] = 8'h66; rv[3] = 1'b1;
    for (int k = 0, re = 0; k < 25; k++) begin
      if (!rv[0] && re < 2 && ph == M_FREE) begin rv[0] = 1'b1; re++; end
      step();
    end
    check("fair_cnt", 64'(served.size()), 64'(4));
    if (served.size() >= 3) begin
      check("fair_0", 64'(served[0]), 64'(0));
      check("fair_1", 64'(served[1]), 64'(3));
      check("fair_2", 64'(served[2]), 64'(0));
    end

    // Reset in READ_WAIT aborts; the thread retries and is served once
    drain();
    served.delete();
    raddr[1] = 8'h77; rv[1] = 1'b1; wait_force = 1000;
    repeat (3) step();
    do_reset = 1'b1; step(); do_reset = 1'b0;
    check("rst_noready", 64'(served.size()), 64'(0));
    wait_force = 1;
    repeat (8) step();
    check("rst_retry_cnt", 64'(served.size()), 64'(1));
    if (served.size() == 1) check("rst_retry_id", 64'(served[0]), 64'(1));

    // Randomised traffic with mixed read/write and random memory latency
    wait_force = -1;
    repeat (400) begin gen_random(); step(); end
    drain();

`ifdef MEM_TIMEOUT_EN
    // Memory never answers thread 0's read
    do_reset = 1'b1; step(); do_reset = 1'b0;
    served.delete();
    raddr[0] = 8'h99; rv[0] = 1'b1; wait_force = 1000;
    repeat (12) step();
    check("to_ready", 64'(served.size()), 64'(1));
    check("to_rdata", 64'(lsu_rdata[0]), 64'(8'hFF));
    check("to_err", 64'(arb_error), 64'(1));
    wait_force = 0;
    waddr[2] = 8'h12; wdata[2] = 8'h34; wv[2] = 1'b1;
    repeat (6) step();
    check("to_sticky", 64'(arb_error), 64'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
